// File: rtl/maze_solve_gen.sv
// maze_solve_gen: maze solver sequencer between cmd_proc and navigate.
// It picks one of four solve policies and steps the heading in quarter turns.
// It sequences the heading-change and forward-move handshakes until sol_cmplt.
// Optional move watchdog: define MS_TMO_EN. In the default build err is tied 0.
module maze_solve_gen #(
    parameter int unsigned HDNG_W = 12,
    parameter int unsigned TCNT_W = 8,
    parameter int unsigned TMO_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_md,
    input  logic [1:0]        cmd,
    input  logic              lft_opn,
    input  logic              rght_opn,
    input  logic              mv_cmplt,
    input  logic              sol_cmplt,
    output logic              strt_hdng,
    output logic [HDNG_W-1:0] dsrd_hdng,
    output logic              strt_mv,
    output logic              stp_lft,
    output logic              stp_rght,
    output logic              busy,
    output logic [TCNT_W-1:0] turn_cnt,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        HDNG_KICK,
        HDNG_WAIT,
        MV_KICK
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        hdng_idx_q, hdng_idx_d;
    logic [1:0]        policy_q, policy_d;
    logic [TCNT_W-1:0] turn_cnt_q, turn_cnt_d;
    logic              strt_hdng_q, strt_hdng_d;
    logic              strt_mv_q, strt_mv_d;
    logic [1:0]        turn_amt;
    logic              lft_first;
    logic              tmo_hit;

    // Pick the heading step for the latched policy: +1 left, +3 right, +2 U-turn
    always_comb begin
        lft_first = (policy_q == 2'b01) || (policy_q == 2'b10);
        turn_amt  = 2'd2;
        if (lft_first) begin
            if (lft_opn)       turn_amt = 2'd1;
            else if (rght_opn) turn_amt = 2'd3;
        end else begin
            if (rght_opn)      turn_amt = 2'd3;
            else if (lft_opn)  turn_amt = 2'd1;
        end
    end

    // Next-state, heading/policy/turn-count updates and the pulses for the next cycle
    always_comb begin
        state_d     = state_q;
        hdng_idx_d  = hdng_idx_q;
        policy_d    = policy_q;
        turn_cnt_d  = turn_cnt_q;
        strt_hdng_d = 1'b0;
        strt_mv_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cmd_md) begin
                    policy_d   = cmd;
                    turn_cnt_d = '0;
                    strt_mv_d  = 1'b1;
                    state_d    = MOVE;
                end
            end
            MOVE: begin
                if (cmd_md || tmo_hit || sol_cmplt) begin
                    state_d = IDLE;
                end else if (mv_cmplt) begin
                    hdng_idx_d  = hdng_idx_q + turn_amt;
                    if (turn_cnt_q != '1) begin
                        turn_cnt_d = turn_cnt_q + 1'b1;
                    end
                    strt_hdng_d = 1'b1;
                    state_d     = HDNG_KICK;
                end
            end
            HDNG_KICK: begin
                state_d = cmd_md ? IDLE : HDNG_WAIT;
            end
            HDNG_WAIT: begin
                if (cmd_md || tmo_hit) begin
                    state_d = IDLE;
                end else if (mv_cmplt) begin
                    strt_mv_d = 1'b1;
                    state_d   = MV_KICK;
                end
            end
            MV_KICK: begin
                state_d = cmd_md ? IDLE : MOVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and heading registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hdng_idx_q  <= '0;
            policy_q    <= '0;
            turn_cnt_q  <= '0;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdng_idx_q  <= hdng_idx_d;
            policy_q    <= policy_d;
            turn_cnt_q  <= turn_cnt_d;
            strt_hdng_q <= strt_hdng_d;
            strt_mv_q   <= strt_mv_d;
        end
    end

`ifdef MS_TMO_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    assign tmo_hit = ((state_q == MOVE) || (state_q == HDNG_WAIT)) && (tmo_cnt_q == '1);

    // Watchdog: restart on every state change, count only while waiting on navigate
    always_comb begin
        err_d = err_q | tmo_hit;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if ((state_q == MOVE) || (state_q == HDNG_WAIT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign strt_hdng = strt_hdng_q;
    assign strt_mv   = strt_mv_q;
    assign dsrd_hdng = {hdng_idx_q, {(HDNG_W-2){1'b0}}};
    assign busy      = (state_q != IDLE);
    assign stp_lft   = busy && (policy_q == 2'b01);
    assign stp_rght  = busy && (policy_q == 2'b00);
    assign turn_cnt  = turn_cnt_q;

endmodule
